// File: rtl/retire_trace_unit.sv
// retire_trace_unit: timestamps register writes and committed stores into an in-order trace FIFO,
// and flags tohost completion and retirement watchdog expiry.
module retire_trace_unit #(
   parameter int XLEN = 32,
   parameter int DEPTH = 8,
   parameter int WDOG_LIMIT = 1000,
   parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h1000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_valid,
   input  logic [XLEN-1:0] wb_tag,
   input  logic [31:0]     wb_instr,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            st_valid,
   input  logic [XLEN-1:0] st_tag,
   input  logic [31:0]     st_instr,
   input  logic [XLEN-1:0] st_addr,
   input  logic [XLEN-1:0] st_data,
   output logic            trace_valid,
   input  logic            trace_ready,
   output logic            trace_kind,
   output logic [31:0]     trace_cycle,
   output logic [XLEN-1:0] trace_tag,
   output logic [31:0]     trace_instr,
   output logic [XLEN-1:0] trace_dest,
   output logic [XLEN-1:0] trace_data,
   output logic            overflow,
   output logic [15:0]     drop_count,
   output logic            finish_seen,
   output logic            done,
   output logic            timeout
);
   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(WDOG_LIMIT + 1);
   localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
   localparam logic [IW-1:0] LIM = IW'(WDOG_LIMIT);
   typedef struct packed {
      logic            kind;
      logic [31:0]     cycle;
      logic [XLEN-1:0] tag;
      logic [31:0]     instr;
      logic [XLEN-1:0] dest;
      logic [XLEN-1:0] data;
   } entry_t;
   entry_t mem [DEPTH];
   entry_t wb_e, st_e, head;
   logic [AW:0] wr_ptr, rd_ptr, occ, free_slots, push_n;
   logic [AW-1:0] wa, sa;
   logic [31:0] cycle_cnt;
   logic [IW-1:0] idle_cnt;
   logic [16:0] dsum;
   logic [1:0] drops;
   logic empty, pop, wb_acc, st_acc;
   always_comb begin
      empty = wr_ptr == rd_ptr;
      trace_valid = !empty;
      pop = trace_valid & trace_ready;
      occ = wr_ptr - rd_ptr;
      // a same-cycle pop frees its slot for this cycle's pushes
      free_slots = DEPTH_P - occ + (AW+1)'(pop);
      wb_acc = wb_valid & (free_slots != '0);
      st_acc = st_valid & (wb_acc ? free_slots >= (AW+1)'(2) : free_slots != '0);
      push_n = (AW+1)'(wb_acc) + (AW+1)'(st_acc);
      drops = 2'(wb_valid & !wb_acc) + 2'(st_valid & !st_acc);
      dsum = {1'b0, drop_count} + 17'(drops);
      wa = wr_ptr[AW-1:0];
      sa = wb_acc ? wa + AW'(1) : wa;
      wb_e = '{kind: 1'b0, cycle: cycle_cnt, tag: wb_tag, instr: wb_instr, dest: XLEN'(wb_rd), data: wb_data};
      st_e = '{kind: 1'b1, cycle: cycle_cnt, tag: st_tag, instr: st_instr, dest: st_addr, data: st_data};
      head = trace_valid ? mem[rd_ptr[AW-1:0]] : '0;
      trace_kind = head.kind;
      trace_cycle = head.cycle;
      trace_tag = head.tag;
      trace_instr = head.instr;
      trace_dest = head.dest;
      trace_data = head.data;
      done = finish_seen & empty;
   end
   always_ff @(posedge clk) begin
      if (wb_acc) mem[wa] <= wb_e;
      if (st_acc) mem[sa] <= st_e;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cycle_cnt <= '0;
         idle_cnt <= '0;
         drop_count <= '0;
         overflow <= 1'b0;
         finish_seen <= 1'b0;
         timeout <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + push_n;
         rd_ptr <= rd_ptr + (AW+1)'(pop);
         cycle_cnt <= cycle_cnt + 32'd1;
         idle_cnt <= wb_valid ? '0 : (idle_cnt == LIM ? idle_cnt : idle_cnt + IW'(1));
         drop_count <= dsum[16] ? 16'hFFFF : dsum[15:0];
         overflow <= overflow | (drops != 2'd0);
         finish_seen <= finish_seen | (st_valid && st_addr == TOHOST_ADDR);
         timeout <= timeout | (idle_cnt == LIM);
      end
   end
endmodule
